// File: rtl/itf_isa_tx.sv
// ISA transmitter: buffers instruction words from the host read path and
// frames them onto the CCU instruction stream, one instruction per opcode.
// Illegal opcodes are dropped and reported through a sticky error flag.
module itf_isa_tx #(
  parameter int PORT_WIDTH     = 128,
  parameter int OPNUM          = 6,
  parameter int OPCODE_WIDTH   = 8,
  parameter int BUF_ADDR_WIDTH = 5,
  parameter int FPS_WORDS      = 16,
  parameter int KNN_WORDS      = 2,
  parameter int SYA_WORDS      = 3,
  parameter int POL_WORDS      = 9,
  parameter int GIC_WORDS      = 2,
  parameter int MON_WORDS      = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PORT_WIDTH-1:0] ISAIn_Dat,
  input  logic                  ISAIn_Vld,
  output logic                  ISAIn_Rdy,
  output logic [PORT_WIDTH-1:0] ITFCCU_ISARdDat,
  output logic                  ITFCCU_ISARdDatVld,
  output logic                  ITFCCU_ISARdDatLast,
  input  logic                  CCUITF_ISARdDatRdy,
  input  logic [OPNUM-1:0]      CCUITF_CfgRdy,
  output logic                  ITF_ISAErr,
  output logic [CNT_WIDTH-1:0]  ITF_InsCnt,
  output logic                  ITF_Busy
);

  localparam int DEPTH = 1 << BUF_ADDR_WIDTH;
  localparam int REM_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, SEND, DROP} state_t;

  // Instruction length in words for a legal opcode.
  function automatic logic [REM_W-1:0] words_for(input logic [OPCODE_WIDTH-1:0] op);
    logic [REM_W-1:0] w;
    case (int'(op))
      0:       w = REM_W'(FPS_WORDS);
      1:       w = REM_W'(KNN_WORDS);
      2:       w = REM_W'(SYA_WORDS);
      3:       w = REM_W'(POL_WORDS);
      4:       w = REM_W'(GIC_WORDS);
      5:       w = REM_W'(MON_WORDS);
      default: w = '0;
    endcase
    return w;
  endfunction

  // Config-ready bit of the target module; out-of-range opcodes read as 0.
  function automatic logic cfg_bit(input logic [OPNUM-1:0]        cfg,
                                   input logic [OPCODE_WIDTH-1:0] op);
    logic b;
    b = 1'b0;
    for (int i = 0; i < OPNUM; i++) begin
      if (int'(op) == i) b = cfg[i];
    end
    return b;
  endfunction

  logic [PORT_WIDTH-1:0]     mem_q [DEPTH];
  logic [BUF_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [BUF_ADDR_WIDTH:0]   fill_q, fill_d;
  logic                      empty, full, push, pop;
  logic [PORT_WIDTH-1:0]     head;
  logic [OPCODE_WIDTH-1:0]   head_op;
  logic                      head_force;

  state_t                    state_q, state_d;
  logic [OPCODE_WIDTH-1:0]   op_q, op_d;
  logic [REM_W-1:0]          rem_q, rem_d;
  logic                      err_q, err_d;
  logic [CNT_WIDTH-1:0]      ins_cnt_q, ins_cnt_d;
  logic                      vld, last;

  assign empty      = (fill_q == '0);
  assign full       = (fill_q == (BUF_ADDR_WIDTH + 1)'(DEPTH));
  assign push       = ISAIn_Vld & ~full;
  assign head       = mem_q[rd_ptr_q];
  assign head_op    = head[OPCODE_WIDTH-1:0];
  assign head_force = head[OPCODE_WIDTH];

  // Buffer storage: data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= ISAIn_Dat;
  end

  // Buffer occupancy after this cycle's push/pop.
  always_comb begin
    fill_d = fill_q;
    case ({push, pop})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Buffer pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      fill_q <= fill_d;
    end
  end

  // Framing FSM: decode header in IDLE, wait for target, stream words, or drop.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    rem_d     = rem_q;
    err_d     = err_q;
    ins_cnt_d = ins_cnt_q;
    pop       = 1'b0;
    vld       = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty) begin
          if (int'(head_op) >= OPNUM) begin
            state_d = DROP;
          end else begin
            op_d    = head_op;
            rem_d   = words_for(head_op);
            state_d = (cfg_bit(CCUITF_CfgRdy, head_op) | head_force) ? SEND : WAIT;
          end
        end
      end
      WAIT: begin
        if (cfg_bit(CCUITF_CfgRdy, op_q)) state_d = SEND;
      end
      SEND: begin
        vld  = ~empty;
        last = vld & (rem_q == REM_W'(1));
        if (vld & CCUITF_ISARdDatRdy) begin
          pop   = 1'b1;
          rem_d = rem_q - REM_W'(1);
          if (last) begin
            state_d   = IDLE;
            ins_cnt_d = ins_cnt_q + CNT_WIDTH'(1);
          end
        end
      end
      DROP: begin
        // Header of an illegal instruction is the only word consumed.
        pop     = 1'b1;
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
      ins_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
      ins_cnt_q <= ins_cnt_d;
    end
  end

  assign ISAIn_Rdy           = ~full;
  assign ITFCCU_ISARdDatVld  = vld;
  assign ITFCCU_ISARdDatLast = last;
  assign ITFCCU_ISARdDat     = vld ? head : '0;
  assign ITF_ISAErr          = err_q;
  assign ITF_InsCnt          = ins_cnt_q;
  assign ITF_Busy            = (state_q != IDLE) | ~empty;

endmodule
